// File: rtl/dff_const_pipe.sv
// DEPTH-stage WIDTH-bit shift pipeline with per-stage reset constants, fill/load select and settle tracking.
// Latency: 1 enabled edge to stage 0, DEPTH enabled edges to q; no backpressure, en=0 simply freezes all state.
module dff_const_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter logic [WIDTH*DEPTH-1:0] RST_VAL = {{(WIDTH*DEPTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] FILL_VAL = {WIDTH{1'b1}},
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   set_reset,
  input  logic                   en,
  input  logic                   load,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH*DEPTH-1:0] stage_q,
  output logic [CW-1:0]          settle_cnt,
  output logic                   settled,
  output logic                   q_edge
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("dff_const_pipe: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("dff_const_pipe: DEPTH must be >= 2");
  end

  logic [WIDTH-1:0] stg_q [DEPTH];
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic [CW-1:0]    settle_cnt_q, settle_cnt_d;
  logic             q_edge_q, q_edge_d;

  always_comb begin
    stg_d        = stg_q;
    settle_cnt_d = settle_cnt_q;
    q_edge_d     = 1'b0;
    if (en) begin
      stg_d[0] = load ? d : FILL_VAL;
      for (int i = 1; i < DEPTH; i++) begin
        stg_d[i] = stg_q[i-1];
      end
      // A load restarts the run; fill shifts count up and saturate at DEPTH.
      if (load) begin
        settle_cnt_d = '0;
      end else if (settle_cnt_q != DEPTH_C) begin
        settle_cnt_d = settle_cnt_q + 1'b1;
      end
      q_edge_d = (stg_q[DEPTH-2] != stg_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge set_reset) begin
    if (set_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg_q[i] <= RST_VAL[i*WIDTH +: WIDTH];
      end
      settle_cnt_q <= '0;
      q_edge_q     <= 1'b0;
    end else begin
      stg_q        <= stg_d;
      settle_cnt_q <= settle_cnt_d;
      q_edge_q     <= q_edge_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign stage_q[g*WIDTH +: WIDTH] = stg_q[g];
  end

  assign q          = stg_q[DEPTH-1];
  assign settle_cnt = settle_cnt_q;
  // Decoded straight from the counter flops so it cannot glitch.
  assign settled    = (settle_cnt_q == DEPTH_C);
  assign q_edge     = q_edge_q;

endmodule

// File: tb/tb_dff_const_pipe.sv
// Directed bench for dff_const_pipe across four parameter sets, checked with immediate assertions.
module tb_dff_const_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: defaults (WIDTH=1, DEPTH=2, RST_VAL=2'b01)
  logic rst0, en0, ld0;
  logic [0:0] d0, q0;
  logic [1:0] sq0, sc0;
  logic st0, qe0;
  // u1: WIDTH=4, DEPTH=3, RST_VAL={0,A,5}
  logic rst1, en1, ld1;
  logic [3:0] d1, q1;
  logic [11:0] sq1;
  logic [1:0] sc1;
  logic st1, qe1;
  // u2: WIDTH=1, DEPTH=4
  logic rst2, en2, ld2;
  logic [0:0] d2, q2;
  logic [3:0] sq2;
  logic [2:0] sc2;
  logic st2, qe2;
  // u3: WIDTH=1, DEPTH=2, RST_VAL equal to FILL_VAL
  logic rst3, en3, ld3;
  logic [0:0] d3, q3;
  logic [1:0] sq3, sc3;
  logic st3, qe3;

  dff_const_pipe u0 (.clk(clk), .set_reset(rst0), .en(en0), .load(ld0), .d(d0), .q(q0),
                     .stage_q(sq0), .settle_cnt(sc0), .settled(st0), .q_edge(qe0));

  dff_const_pipe #(.WIDTH(4), .DEPTH(3), .RST_VAL(12'h0A5)) u1 (
    .clk(clk), .set_reset(rst1), .en(en1), .load(ld1), .d(d1), .q(q1),
    .stage_q(sq1), .settle_cnt(sc1), .settled(st1), .q_edge(qe1));

  dff_const_pipe #(.WIDTH(1), .DEPTH(4)) u2 (
    .clk(clk), .set_reset(rst2), .en(en2), .load(ld2), .d(d2), .q(q2),
    .stage_q(sq2), .settle_cnt(sc2), .settled(st2), .q_edge(qe2));

  dff_const_pipe #(.WIDTH(1), .DEPTH(2), .RST_VAL(2'b11)) u3 (
    .clk(clk), .set_reset(rst3), .en(en3), .load(ld3), .d(d3), .q(q3),
    .stage_q(sq3), .settle_cnt(sc3), .settled(st3), .q_edge(qe3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1; en0 = 0; ld0 = 0; d0 = '0;
    rst1 = 1; en1 = 0; ld1 = 0; d1 = '0;
    rst2 = 1; en2 = 0; ld2 = 0; d2 = '0;
    rst3 = 1; en3 = 0; ld3 = 0; d3 = '0;
    #2;

    // ---- u0: reset state, then two fill edges
    chk("u0 rst q", q0, 0);
    chk("u0 rst stage_q", sq0, 2'b01);
    chk("u0 rst settled", st0, 0);
    chk("u0 rst settle_cnt", sc0, 0);
    chk("u0 rst q_edge", qe0, 0);
    tick();
    rst0 = 0; en0 = 1; ld0 = 0;
    tick();
    chk("u0 e1 stage_q", sq0, 2'b11);
    chk("u0 e1 q", q0, 1);
    chk("u0 e1 q_edge", qe0, 1);
    chk("u0 e1 settle_cnt", sc0, 1);
    chk("u0 e1 settled", st0, 0);
    tick();
    chk("u0 e2 settle_cnt", sc0, 2);
    chk("u0 e2 settled", st0, 1);
    chk("u0 e2 q_edge", qe0, 0);
    tick();
    chk("u0 sat settle_cnt", sc0, 2);

    // ---- u0: asynchronous reset mid-period while settled
    #3;
    rst0 = 1;
    #1;
    chk("u0 async q", q0, 0);
    chk("u0 async stage_q", sq0, 2'b01);
    chk("u0 async settle_cnt", sc0, 0);
    chk("u0 async settled", st0, 0);
    tick();
    chk("u0 held stage_q", sq0, 2'b01);
    chk("u0 held settle_cnt", sc0, 0);
    rst0 = 0;
    tick();
    chk("u0 rel e1 settled", st0, 0);
    tick();
    chk("u0 rel e2 settled", st0, 1);

    // ---- u0: disabled edges pause; load with en=0 does not clear
    en0 = 0; ld0 = 1; d0 = 1'b0;
    tick();
    chk("u0 ld_noen settle_cnt", sc0, 2);
    chk("u0 ld_noen stage_q", sq0, 2'b11);
    rst0 = 1;
    #1;
    rst0 = 0; ld0 = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("u0 en0 stage_q", sq0, 2'b01);
    chk("u0 en0 settle_cnt", sc0, 0);
    chk("u0 en0 q_edge", qe0, 0);
    en0 = 1;
    tick();
    tick();
    chk("u0 en1x2 settled", st0, 1);
    en0 = 0;

    // ---- u1: WIDTH=4 DEPTH=3 load sequence then fill
    rst1 = 0; en1 = 1; ld1 = 1; d1 = 4'h3;
    tick();
    chk("u1 e1 q", q1, 4'hA);
    chk("u1 e1 q_edge", qe1, 1);
    chk("u1 e1 settle_cnt", sc1, 0);
    d1 = 4'h5;
    tick();
    chk("u1 e2 q", q1, 4'h5);
    chk("u1 e2 q_edge", qe1, 1);
    d1 = 4'h9;
    tick();
    chk("u1 e3 q", q1, 4'h3);
    chk("u1 e3 stage_q", sq1, 12'h359);
    chk("u1 e3 q_edge", qe1, 1);
    chk("u1 e3 settle_cnt", sc1, 0);
    ld1 = 0;
    tick();
    chk("u1 e4 q", q1, 4'h5);
    chk("u1 e4 q_edge", qe1, 1);
    chk("u1 e4 settle_cnt", sc1, 1);
    tick();
    chk("u1 e5 q", q1, 4'h9);
    chk("u1 e5 q_edge", qe1, 1);
    chk("u1 e5 settled", st1, 0);
    tick();
    chk("u1 e6 q", q1, 4'hF);
    chk("u1 e6 settled", st1, 1);
    chk("u1 e6 stage_q", sq1, 12'hFFF);
    tick();
    chk("u1 e7 q_edge", qe1, 0);
    chk("u1 e7 settle_cnt", sc1, 3);

    // ---- u2: DEPTH=4 with en toggling
    rst2 = 0; ld2 = 0;
    for (int i = 1; i <= 7; i++) begin
      en2 = (i % 2 == 1);
      tick();
      if (i == 2) chk("u2 disabled q_edge", qe2, 0);
      if (i == 6) chk("u2 e6 settled", st2, 0);
      if (i == 6) chk("u2 e6 settle_cnt", sc2, 3);
    end
    chk("u2 e7 settled", st2, 1);
    chk("u2 e7 q", q2, 1);
    en2 = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("u2 sat settle_cnt", sc2, 4);
    end
    chk("u2 sat settled", st2, 1);

    // ---- u3: reset value equals fill value
    rst3 = 0; en3 = 1; ld3 = 0;
    tick();
    chk("u3 e1 q_edge", qe3, 0);
    chk("u3 e1 settled", st3, 0);
    chk("u3 e1 settle_cnt", sc3, 1);
    tick();
    chk("u3 e2 q_edge", qe3, 0);
    chk("u3 e2 settled", st3, 1);
    tick();
    chk("u3 e3 q_edge", qe3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_const_pipe.md
# dff_const_pipe

Parametrised successor to the single-bit constant-flop pair used in our sequential-optimisation experiments. It is a DEPTH-stage, WIDTH-bit register pipeline. Each stage asynchronously resets to its own constant, and on every enabled clock edge the pipeline shifts in either a fixed fill constant or live data. Status outputs report when the pipeline has settled to the fill value and when the output word changes. It serves as the parametrised test vehicle for constant-propagation and retiming experiments in synthesis, and as a reset-release sequencer.

## Interface
Parameters:
- WIDTH, 1, bits per stage (≥1)
- DEPTH, 2, number of stages (≥2); stage 0 is nearest the input, stage DEPTH-1 drives q
- RST_VAL, {WIDTH*DEPTH{1'b0}} with bit 0 = 1 (default 2'b01), per-stage reset constants; slice [i*WIDTH +: WIDTH] belongs to stage i
- FILL_VAL, {WIDTH{1'b1}}, constant shifted into stage 0 when load=0
- CW, $clog2(DEPTH+1), settle-counter width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- set_reset  in  1  asynchronous, active-high reset
- en  in  1  shift enable
- load  in  1  1: stage 0 takes d; 0: stage 0 takes FILL_VAL
- d  in  WIDTH  live data for stage 0
- q  out  WIDTH  stage DEPTH-1 contents
- stage_q  out  WIDTH*DEPTH  all stage contents, same slicing as RST_VAL
- settle_cnt  out  CW  consecutive enabled fill shifts, saturating
- settled  out  1  settle_cnt == DEPTH
- q_edge  out  1  q changed at the last clock edge

## Operation
- Reset (set_reset=1, asynchronous):
  - stage[i] = RST_VAL slice i
  - settle_cnt = 0, settled = 0, q_edge = 0
  - q = RST_VAL slice DEPTH-1
  - Assertion takes effect immediately, independent of clk. While asserted, all clock edges are ignored.
- Enabled edge (en=1, reset low):
  - stage[0] <= load ? d : FILL_VAL
  - stage[i] <= stage[i-1] for i ≥ 1
  - If load=1: settle_cnt <= 0.
  - If load=0: settle_cnt <= min(settle_cnt+1, DEPTH).
  - q_edge <= (stage[DEPTH-2] != stage[DEPTH-1]), i.e. set when q changes at this edge.
- Disabled edge (en=0): all stages and settle_cnt hold; q_edge <= 0.
- settled is combinational from settle_cnt and must be glitch-free; implement it as a compare on the register output.
- While settled=1, every stage equals FILL_VAL.
- Reset contents are not counted toward settling, even if RST_VAL equals FILL_VAL.

## Timing
- Latency:
  - d or FILL_VAL to stage 0: 1 enabled edge
  - to q: DEPTH enabled edges
- settled rises after exactly DEPTH consecutive enabled edges with load=0 following reset release or the last load=1 edge. Edges with en=0 do not break the run; they pause it.
- settle_cnt saturates at DEPTH and never wraps.
- Reset release is not synchronised inside the block; the first rising edge after set_reset falls is a normal edge.
- Reset asserted mid-run: all outputs return to their reset values immediately, and settle_cnt restarts from 0 on release.
- load=1 and en=0 on the same edge: nothing changes, and settle_cnt is not cleared.

## Test plan
- Defaults, set_reset=1: q=0, stage_q=2'b01, settled=0. Release, then 1 edge with en=1, load=0: stage_q=2'b11, q=1, q_edge=1, settle_cnt=1. 2nd edge: settle_cnt=2, settled=1, q_edge=0.
- Defaults, en=0 for 5 edges after release: stage_q=2'b01, settle_cnt=0, q_edge=0. Then en=1 for 2 edges: settled=1.
- WIDTH=4, DEPTH=3, load=1 with d=3,5,9 on consecutive edges: q=3 on edge 3, 5 on edge 4, 9 on edge 5, q_edge=1 each edge, settle_cnt=0. Switch to load=0: settled=1 exactly 3 edges later, q=4'hF.
- Assert set_reset asynchronously mid-clock-period while settled=1: q, stage_q and settle_cnt take their reset values before the next edge. Release: re-settles after DEPTH edges.
- DEPTH=4, load=0 with en toggling 1,0,1,0,1,0,1: settled rises on the 4th enabled edge (edge 7) and stays high; settle_cnt stays at 4 for 10 further edges.
- RST_VAL equal to FILL_VAL, DEPTH=2: no q_edge on any edge, and settled still takes 2 enabled edges.
